alu_seq: RTL and testbench

Single-accumulator instruction sequencer that drives the combinational ALU from the other side of its `inst`/`a`/`b`/`ans` interface. It fetches 12-bit instruction words from a program memory over a req/ack handshake, decodes the opcode, presents operands to the ALU, and writes `ans` back into an 8-bit accumulator plus carry flag. It also executes jump and halt opcodes itself. It sits between the program ROM and the ALU, and owns the PC, the instruction register and the accumulator.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_seq_if.sv | 28 ++
 rtl/alu_seq_acc_reg.sv | 36 +++
 rtl/alu_seq.sv | 99 +++++++++
 tb/tb_alu_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its sequencer: opcodes, sequencer states
// and default datapath widths.
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int PC_W_DEF   = 8;

    localparam logic [3:0] OP_PASSB = 4'h0;
    localparam logic [3:0] OP_PASSA = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_AND   = 4'h4;
    localparam logic [3:0] OP_INC   = 4'h5;
    localparam logic [3:0] OP_DEC   = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_NOP   = 4'h8;
    localparam logic [3:0] OP_CLR   = 4'h9;
    localparam logic [3:0] OP_IOR   = 4'hA;
    localparam logic [3:0] OP_SWAP  = 4'hB;
    localparam logic [3:0] OP_JMP   = 4'hC;
    localparam logic [3:0] OP_JZ    = 4'hD;
    localparam logic [3:0] OP_JC    = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_FETCH  = 2'd1,
        SEQ_EXEC   = 2'd2,
        SEQ_HALTED = 2'd3
    } seq_state_e;

    // Opcodes whose ALU result is written back into acc/carry.
    function automatic logic op_writes_acc(input logic [3:0] op);
        return (op <= OP_SWAP) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Bus between the sequencer (master), the program ROM and the combinational ALU.
interface alu_seq_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    // Fetch handshake: the master raises imem_req with imem_addr and holds both
    // unchanged until it samples imem_ack high on a rising edge; imem_data is
    // captured on that same edge. imem_ack is ignored while imem_req is low.
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [DATA_W+3:0] imem_data;

    logic [3:0]        alu_inst;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W:0]   alu_ans;

    modport master (
        output imem_req, imem_addr, alu_inst, alu_a, alu_b,
        input  imem_ack, imem_data, alu_ans
    );

    modport slave (
        input  imem_req, imem_addr, alu_inst, alu_a, alu_b,
        output imem_ack, imem_data, alu_ans
    );
endinterface

// File: rtl/alu_seq_acc_reg.sv
// Accumulator and carry flag, loaded together from the ALU result when enabled.
module acc_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [DATA_W:0]   ans,
    output logic [DATA_W-1:0] acc,
    output logic              carry
);
    logic [DATA_W-1:0] acc_d, acc_q;
    logic              carry_d, carry_q;

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        if (we) begin
            acc_d   = ans[DATA_W-1:0];
            carry_d = ans[DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign acc   = acc_q;
    assign carry = carry_q;
endmodule

// File: rtl/alu_seq.sv
// Single-accumulator sequencer: fetches instructions, drives the ALU, writes
// results back, and executes jumps and HALT itself.
module alu_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    alu_seq_if.master         bus,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              halted,
    output logic [1:0]        dbg_state
);
    localparam logic [1:0] ST_IDLE   = 2'(SEQ_IDLE);
    localparam logic [1:0] ST_FETCH  = 2'(SEQ_FETCH);
    localparam logic [1:0] ST_EXEC   = 2'(SEQ_EXEC);
    localparam logic [1:0] ST_HALTED = 2'(SEQ_HALTED);

    logic [1:0]        state_d, state_q;
    logic [PC_W-1:0]   pc_d, pc_q;
    logic [DATA_W+3:0] ir_d, ir_q;
    logic [3:0]        opcode;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   target;
    logic [3:0]        alu_inst_c;
    logic              acc_we;

    assign opcode = ir_q[DATA_W+3:DATA_W];
    assign pc_inc = pc_q + PC_W'(1);
    assign target = ir_q[PC_W-1:0];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        alu_inst_c = OP_NOP;
        acc_we     = 1'b0;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_FETCH;
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_data;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (opcode == OP_HALT) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = run ? ST_FETCH : ST_IDLE;
                    case (opcode)
                        OP_JMP:  pc_d = target;
                        OP_JZ:   pc_d = (acc == '0) ? target : pc_inc;
                        OP_JC:   pc_d = carry ? target : pc_inc;
                        default: pc_d = pc_inc;
                    endcase
                end
                if (op_writes_acc(opcode)) begin
                    alu_inst_c = opcode;
                    acc_we     = 1'b1;
                end
            end
            default: if (!run) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    acc_reg #(.DATA_W(DATA_W)) u_acc_reg (
        .clk   (clk),
        .reset (reset),
        .we    (acc_we),
        .ans   (bus.alu_ans),
        .acc   (acc),
        .carry (carry)
    );

    assign bus.imem_req  = (state_q == ST_FETCH);
    assign bus.imem_addr = pc_q;
    assign bus.alu_inst  = alu_inst_c;
    assign bus.alu_a     = acc;
    assign bus.alu_b     = ir_q[DATA_W-1:0];
    assign halted        = (state_q == ST_HALTED);
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: ROM responder with variable ack delay, a behavioural ALU,
// and an instruction-level reference model of the accumulator machine.
module tb_alu_seq;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  always #5 clk = ~clk;

  alu_seq_if #(.DATA_W(8), .PC_W(8)) bus ();
  logic [7:0] acc;
  logic       carry;
  logic       halted;
  logic [1:0] dbg_state;

  alu_seq #(.DATA_W(8), .PC_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .bus       (bus),
    .acc       (acc),
    .carry     (carry),
    .halted    (halted),
    .dbg_state (dbg_state)
  );

  // Behavioural ALU: 9-bit results, bit 8 is carry/borrow.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    case (op)
      4'h0: r = b;
      4'h1: r = a;
      4'h2: r = a + b;
      4'h3: r = a - b;
      4'h4: r = a & b;
      4'h5: r = a + 1;
      4'h6: r = a - 1;
      4'h7: r = a ^ b;
      4'h9: r = 0;
      4'hA: r = a | b;
      4'hB: r = {b[3:0], b[7:4]};
      default: r = 0;
    endcase
    return 9'(r & 'h1FF);
  endfunction

  assign bus.alu_ans = alu_fn(bus.alu_inst, bus.alu_a, bus.alu_b);

  logic [11:0] mem [256];

  // ---------------- reference model ----------------
  int m_pc, m_acc, m_carry, m_halted;

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_carry = 0; m_halted = 0;
  endtask

  function automatic bit is_alu_op(input int op);
    return (op <= 11) && (op != 8);
  endfunction

  task automatic model_step(input logic [11:0] instr);
    int op, imm, r;
    op = int'(instr[11:8]);
    imm = int'(instr[7:0]);
    if (is_alu_op(op)) begin
      r = int'(alu_fn(instr[11:8], 8'(m_acc), instr[7:0]));
      m_acc = r % 256;
      m_carry = r / 256;
      m_pc = (m_pc + 1) % 256;
    end else if (op == 12) m_pc = imm;
    else if (op == 13) m_pc = (m_acc == 0) ? imm : (m_pc + 1) % 256;
    else if (op == 14) m_pc = (m_carry == 1) ? imm : (m_pc + 1) % 256;
    else if (op == 15) m_halted = 1;
    else m_pc = (m_pc + 1) % 256;
  endtask

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // Serve one fetch (ack after 'delay' wait cycles), then check the EXEC cycle.
  task automatic exec_one(input int delay, input bit drop_run, output int req_cycles);
    int budget;
    logic [11:0] instr;
    int op;
    req_cycles = 0;
    budget = 0;
    while (bus.imem_req !== 1'b1 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (bus.imem_req !== 1'b1) begin
      check_eq("req_timeout", 32'(bus.imem_req), 32'd1);
      return;
    end
    check_eq("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
    instr = mem[m_pc];
    op = int'(instr[11:8]);
    req_cycles = 1;
    if (drop_run) run = 1'b0;
    for (int i = 0; i < delay; i++) begin
      bus.imem_ack = 1'b0;
      bus.imem_data = 12'($urandom);
      @(negedge clk);
      req_cycles++;
      check_eq("req_held", 32'(bus.imem_req), 32'd1);
      check_eq("addr_held", 32'(bus.imem_addr), 32'(m_pc));
    end
    bus.imem_ack = 1'b1;
    bus.imem_data = instr;
    @(negedge clk);
    bus.imem_ack = 1'($urandom_range(0, 1));
    bus.imem_data = 12'($urandom);
    check_eq("exec_alu_inst", 32'(bus.alu_inst), is_alu_op(op) ? 32'(op) : 32'h8);
    check_eq("exec_alu_a", 32'(bus.alu_a), 32'(m_acc));
    check_eq("exec_alu_b", 32'(bus.alu_b), 32'(instr[7:0]));
    @(negedge clk);
    bus.imem_ack = 1'b0;
    model_step(instr);
    check_eq("acc", 32'(acc), 32'(m_acc));
    check_eq("carry", 32'(carry), 32'(m_carry));
    check_eq("halted", 32'(halted), 32'(m_halted));
    check_eq("req_after_exec", 32'(bus.imem_req), (m_halted == 0 && run) ? 32'd1 : 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rc;
    bus.imem_ack = 1'b0;
    bus.imem_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(bus.imem_req), 32'd0);
    check_eq("rst_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("rst_acc", 32'(acc), 32'd0);
    check_eq("rst_carry", 32'(carry), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_alu_inst", 32'(bus.alu_inst), 32'h8);
    check_eq("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check_eq("rst_alu_b", 32'(bus.alu_b), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(SEQ_IDLE));
    reset = 1'b1;

    // LDI 5, ADD 0xFF, HALT
    for (int i = 0; i < 256; i++) mem[i] = 12'h800;
    mem[0] = 12'h005; mem[1] = 12'h2FF; mem[2] = 12'hF00;
    run = 1'b1;
    for (int i = 0; i < 3; i++) exec_one(0, 1'b0, rc);
    check_eq("p1_acc", 32'(acc), 32'h04);
    check_eq("p1_carry", 32'(carry), 32'd1);
    check_eq("p1_halted", 32'(halted), 32'd1);
    check_eq("p1_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    check_eq("halt_stays", 32'(halted), 32'd1);
    run = 1'b0;
    @(negedge clk);
    check_eq("halt_to_idle", 32'(dbg_state), 32'(SEQ_IDLE));
    check_eq("halt_cleared", 32'(halted), 32'd0);
    do_reset();

    // Arithmetic, swap, NOP, run control, jumps and wrap
    mem[0] = 12'h003; mem[1] = 12'h305; mem[2] = 12'h40F; mem[3] = 12'hBA5;
    mem[4] = 12'h800; mem[5] = 12'h900; mem[6] = 12'hD40;
    mem[8'h40] = 12'h001; mem[8'h41] = 12'hD10; mem[8'h42] = 12'hCFF; mem[8'hFF] = 12'h800;
    run = 1'b1;
    exec_one(0, 1'b0, rc);
    exec_one(1, 1'b0, rc);
    check_eq("sub_acc", 32'(acc), 32'hFE);
    check_eq("sub_borrow", 32'(carry), 32'd1);
    exec_one(0, 1'b0, rc);
    check_eq("and_acc", 32'(acc), 32'h0E);
    check_eq("and_carry", 32'(carry), 32'd0);
    exec_one(3, 1'b0, rc);
    check_eq("delay_req_cycles", 32'(rc), 32'd4);
    check_eq("swap_acc", 32'(acc), 32'h5A);
    exec_one(0, 1'b0, rc);
    check_eq("nop_acc", 32'(acc), 32'h5A);
    check_eq("nop_pc", 32'(bus.imem_addr), 32'h05);
    exec_one(1, 1'b1, rc);
    check_eq("stop_state", 32'(dbg_state), 32'(SEQ_IDLE));
    repeat (2) @(negedge clk);
    check_eq("stop_no_req", 32'(bus.imem_req), 32'd0);
    run = 1'b1;
    @(negedge clk);
    check_eq("resume_addr", 32'(bus.imem_addr), 32'h06);
    exec_one(0, 1'b0, rc);
    check_eq("jz_taken", 32'(bus.imem_addr), 32'h40);
    exec_one(0, 1'b0, rc);
    exec_one(2, 1'b0, rc);
    check_eq("jz_not_taken", 32'(bus.imem_addr), 32'h42);
    exec_one(0, 1'b0, rc);
    check_eq("jmp_ff", 32'(bus.imem_addr), 32'hFF);
    exec_one(0, 1'b0, rc);
    check_eq("pc_wrap", 32'(bus.imem_addr), 32'h00);

    // Reset during a pending fetch
    check_eq("mid_fetch_req", 32'(bus.imem_req), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("mr_req", 32'(bus.imem_req), 32'd0);
    check_eq("mr_addr", 32'(bus.imem_addr), 32'd0);
    check_eq("mr_acc", 32'(acc), 32'd0);
    check_eq("mr_carry", 32'(carry), 32'd0);
    check_eq("mr_halted", 32'(halted), 32'd0);
    check_eq("mr_alu_inst", 32'(bus.alu_inst), 32'h8);
    check_eq("mr_alu_b", 32'(bus.alu_b), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    // Random programs
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    for (int n = 0; n < 250; n++) begin
      bit drop;
      drop = ($urandom_range(0, 7) == 0);
      exec_one($urandom_range(0, 3), drop, rc);
      if (m_halted != 0) begin
        run = 1'b0;
        @(negedge clk);
        check_eq("rnd_halt_idle", 32'(dbg_state), 32'(SEQ_IDLE));
        mem[m_pc] = {4'($urandom_range(0, 14)), 8'($urandom)};
        m_halted = 0;
      end
      run = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
